// File: rtl/multimode_flipflop_bank.sv
// Bank of WIDTH flip-flops with a shared run-time mode (SR, JK, D, T).
// It also records SR forbidden inputs in sticky per-channel flags and a saturating event counter.
module multimode_flipflop_bank #(
  parameter int unsigned            WIDTH   = 4,
  parameter int unsigned            CNT_W   = 8,
  parameter logic [WIDTH-1:0]       RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] inv_flag,
  output logic [CNT_W-1:0] inv_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] inv_set;
  logic [WIDTH-1:0] flag_next;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    q_next  = q;
    inv_set = '0;
    if (en) begin
      unique case (mode)
        MODE_SR: begin
          // S=R=1 holds the bit and is reported as forbidden.
          q_next  = (a & ~b) | (q & ~(a ^ b));
          inv_set = a & b;
        end
        MODE_JK: q_next = (a & ~q) | (~b & q);
        MODE_D:  q_next = a;
        MODE_T:  q_next = q ^ a;
        default: q_next = q;
      endcase
    end
  end

  // A same-edge set overrides err_clr on that channel.
  always_comb begin
    flag_next = (inv_flag & ~{WIDTH{err_clr}}) | inv_set;
    cnt_next  = inv_cnt;
    if ((|inv_set) && (inv_cnt != CNT_MAX)) begin
      cnt_next = inv_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= RST_VAL;
      inv_flag <= '0;
      inv_cnt  <= '0;
    end else begin
      q        <= q_next;
      inv_flag <= flag_next;
      inv_cnt  <= cnt_next;
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_multimode_flipflop_bank.sv
// Scoreboard bench for multimode_flipflop_bank (WIDTH=4, CNT_W=3, RST_VAL=0).
// The stimulus process queues hand-computed expectations, and a monitor process checks them after each edge.
module tb_multimode_flipflop_bank;

  localparam int W = 4;
  localparam int C = 3;

  localparam logic [1:0] SR = 2'b00;
  localparam logic [1:0] JK = 2'b01;
  localparam logic [1:0] D  = 2'b10;
  localparam logic [1:0] T  = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic [W-1:0] inv_flag;
  logic [C-1:0] inv_cnt;

  typedef struct packed {
    logic [7:0]   id;
    logic [W-1:0] q;
    logic [W-1:0] flag;
    logic [C-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  multimode_flipflop_bank #(.WIDTH(W), .CNT_W(C), .RST_VAL(4'b0000)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q), .qb(qb), .inv_flag(inv_flag), .inv_cnt(inv_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] id, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b, expected %b", name, id, act, req);
    end
  endtask

  // Monitor: one expectation per edge, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q",        e.id, {4'b0, q},        {4'b0, e.q});
        check("qb",       e.id, {4'b0, qb},       {4'b0, ~e.q});
        check("inv_flag", e.id, {4'b0, inv_flag}, {4'b0, e.flag});
        check("inv_cnt",  e.id, {5'b0, inv_cnt},  {5'b0, e.cnt});
      end
    end
  end

  task automatic step(input logic r, input logic e_n, input logic [1:0] m,
                      input logic [W-1:0] av, input logic [W-1:0] bv, input logic clr,
                      input logic [W-1:0] xq, input logic [W-1:0] xf, input logic [C-1:0] xc);
    exp_t e;
    @(negedge clk);
    rst = r; en = e_n; mode = m; a = av; b = bv; err_clr = clr;
    step_id++;
    e.id = step_id[7:0]; e.q = xq; e.flag = xf; e.cnt = xc;
    exp_q.push_back(e);
  endtask

  initial begin
    // reset
    step(1, 0, SR, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0);
    // SR set/reset/hold
    step(0, 1, SR, 4'b0011, 4'b1100, 0, 4'b0011, 4'b0000, 3'd0);
    step(0, 1, SR, 4'b0000, 4'b0000, 0, 4'b0011, 4'b0000, 3'd0);
    step(0, 1, SR, 4'b1000, 4'b0001, 0, 4'b1010, 4'b0000, 3'd0);
    // load 0101 via D, then an SR forbidden input on channel 2
    step(0, 1, D,  4'b0101, 4'b0000, 0, 4'b0101, 4'b0000, 3'd0);
    step(0, 1, SR, 4'b1100, 4'b0100, 0, 4'b1101, 4'b0100, 3'd1);
    step(0, 0, SR, 4'b1111, 4'b1111, 1, 4'b1101, 4'b0000, 3'd1);
    // JK toggle, then T mode
    step(1, 1, JK, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 3'd0);
    step(0, 1, JK, 4'b1111, 4'b1111, 0, 4'b1111, 4'b0000, 3'd0);
    step(0, 1, JK, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 3'd0);
    step(0, 1, JK, 4'b1111, 4'b1111, 0, 4'b1111, 4'b0000, 3'd0);
    step(0, 1, JK, 4'b1010, 4'b0110, 0, 4'b1001, 4'b0000, 3'd0);
    step(1, 1, T,  4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0);
    step(0, 1, T,  4'b0101, 4'b1111, 0, 4'b0101, 4'b0000, 3'd0);
    step(0, 1, T,  4'b0101, 4'b1111, 0, 4'b0000, 4'b0000, 3'd0);
    // D with enable gating, then a mid-operation reset
    step(0, 1, D,  4'b1010, 4'b0000, 0, 4'b1010, 4'b0000, 3'd0);
    step(0, 0, D,  4'b0110, 4'b0000, 0, 4'b1010, 4'b0000, 3'd0);
    step(0, 1, D,  4'b0011, 4'b0000, 0, 4'b0011, 4'b0000, 3'd0);
    step(1, 1, D,  4'b1111, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0);
    // forbidden SR input while disabled is not detected
    step(0, 0, SR, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 3'd0);
    // counter saturation
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, SR, 4'b1111, 4'b1111, 0, 4'b0000, 4'b1111, (i > 7) ? 3'd7 : 3'(i));
    end
    // err_clr with a same-edge set on channel 0
    step(0, 1, SR, 4'b0001, 4'b0001, 1, 4'b0000, 4'b0001, 3'd7);
    // err_clr leaves the count alone; reset clears it
    step(0, 0, SR, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 3'd7);
    step(1, 1, SR, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 3'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
